// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and exponent limits for the sigfmd round/pack pipe
package fpu_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RZ  = 2'd1,
    RU  = 2'd2,
    RD  = 2'd3
  } rm_t;

  localparam int EXP_W  = 13;
  localparam int FRAC_W = 52;

  localparam int EMAX_D = 1023;
  localparam int EMIN_D = -1022;
  localparam int EMAX_S = 127;
  localparam int EMIN_S = -126;
  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;

  // frac holds the significand without its hidden bit; singles sit in frac[22:0]
  typedef struct packed {
    logic [FRAC_W-1:0]      frac;
    logic                   g;
    logic                   st;
    logic signed [EXP_W:0]  e1;
    logic                   sign;
    logic                   db;
    rm_t                    rm;
  } s1_t;

endpackage

// File: rtl/round_dec.sv
// rtl/round_dec.sv - round-increment and inexact decision for one normalised significand
module round_dec
  import fpu_pkg::*;
(
  input  logic lsb,
  input  logic g,
  input  logic st,
  input  logic sign,
  input  rm_t  rm,
  output logic inc,
  output logic inx
);

  always_comb begin
    inc = 1'b0;
    inx = g | st;
    case (rm)
      RNE:     inc = g & (st | lsb);
      RZ:      inc = 1'b0;
      RU:      inc = ~sign & (g | st);
      RD:      inc = sign & (g | st);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/sigfmd_round_pipe.sv
// rtl/sigfmd_round_pipe.sv - two-stage normalise/round/pack of sigfmd output to IEEE double/single
module sigfmd_round_pipe
  import fpu_pkg::*;
#(
  parameter int EW  = EXP_W,
  parameter int FQW = 57
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FQW-1:0]       fq,
  input  logic                 sign,
  input  logic signed [EW-1:0] exp,
  input  logic                 db,
  input  logic [1:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          res,
  output logic                 f_inx,
  output logic                 f_ovf,
  output logic                 f_unf
);

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  s1_t  s1_d;
  s1_t  s1_q;

  assign s2_load   = ~s2_valid | out_ready;
  assign s1_load   = ~s1_valid | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Stage 1: fq/2^55 lies in [1,4); fq[56] picks which bit is the hidden one
  always_comb begin
    s1_d      = '0;
    s1_d.e1   = {exp[EW-1], exp} + (EW+1)'(fq[56]);
    s1_d.sign = sign;
    s1_d.db   = db;
    s1_d.rm   = rm_t'(rm);
    if (db) begin
      s1_d.frac = fq[56] ? fq[55:4] : fq[54:3];
      s1_d.g    = fq[56] ? fq[3] : fq[2];
      s1_d.st   = fq[56] ? |fq[2:0] : |fq[1:0];
    end else begin
      s1_d.frac = {29'd0, (fq[56] ? fq[55:33] : fq[54:32])};
      s1_d.g    = fq[56] ? fq[32] : fq[31];
      s1_d.st   = fq[56] ? |fq[31:0] : |fq[30:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  logic                 inc;
  logic                 inx_r;
  logic [FRAC_W:0]      fsum;
  logic                 carry;
  logic                 to_inf;
  logic signed [EW+1:0] e_fin;
  logic signed [EW+1:0] emax;
  logic signed [EW+1:0] emin;
  logic [63:0]          res_d;
  logic                 inx_d;
  logic                 ovf_d;
  logic                 unf_d;

  round_dec u_round_dec (
    .lsb  (s1_q.frac[0]),
    .g    (s1_q.g),
    .st   (s1_q.st),
    .sign (s1_q.sign),
    .rm   (s1_q.rm),
    .inc  (inc),
    .inx  (inx_r)
  );

  // Stage 2: carry out of the fraction means the significand rounded up to 2.0
  always_comb begin
    fsum   = {1'b0, s1_q.frac} + (FRAC_W+1)'(inc);
    carry  = s1_q.db ? fsum[FRAC_W] : fsum[23];
    e_fin  = {s1_q.e1[EW], s1_q.e1} + (EW+2)'(carry);
    emax   = s1_q.db ? (EW+2)'(EMAX_D) : (EW+2)'(EMAX_S);
    emin   = s1_q.db ? (EW+2)'(EMIN_D) : (EW+2)'(EMIN_S);
    to_inf = (s1_q.rm == RNE) | ((s1_q.rm == RU) & ~s1_q.sign) | ((s1_q.rm == RD) & s1_q.sign);
    res_d  = '0;
    inx_d  = inx_r;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (e_fin > emax) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      if (s1_q.db) begin
        res_d = to_inf ? {s1_q.sign, 11'h7FF, 52'd0} : {s1_q.sign, 11'h7FE, {52{1'b1}}};
      end else begin
        res_d = {32'd0, (to_inf ? {s1_q.sign, 8'hFF, 23'd0} : {s1_q.sign, 8'hFE, {23{1'b1}}})};
      end
    end else if (e_fin < emin) begin
      unf_d = 1'b1;
      inx_d = 1'b1;
      res_d = s1_q.db ? {s1_q.sign, 63'd0} : {32'd0, s1_q.sign, 31'd0};
    end else if (s1_q.db) begin
      res_d = {s1_q.sign, 11'(e_fin + (EW+2)'(BIAS_D)), fsum[51:0]};
    end else begin
      res_d = {32'd0, s1_q.sign, 8'(e_fin + (EW+2)'(BIAS_S)), fsum[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res      <= '0;
      f_inx    <= 1'b0;
      f_ovf    <= 1'b0;
      f_unf    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res   <= res_d;
        f_inx <= inx_d;
        f_ovf <= ovf_d;
        f_unf <= unf_d;
      end
    end
  end

  a_fq_legal: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> (fq[56:55] != 2'b00));

endmodule

// File: tb/tb_sigfmd_round_pipe.sv
// tb/tb_sigfmd_round_pipe.sv - directed vector bench for sigfmd_round_pipe
module tb_sigfmd_round_pipe;
  import fpu_pkg::*;

  typedef struct {
    logic               db;
    rm_t                rm;
    logic               sign;
    logic signed [12:0] exp;
    logic [56:0]        fq;
    logic [63:0]        res;
    logic [2:0]         flg;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [56:0]        fq = 57'h0080_0000_0000_0000;
  logic               sign = 1'b0;
  logic signed [12:0] exp = '0;
  logic               db = 1'b1;
  logic [1:0]         rm = 2'd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [63:0]        res;
  logic               f_inx;
  logic               f_ovf;
  logic               f_unf;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sigfmd_round_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fq        (fq),
    .sign      (sign),
    .exp       (exp),
    .db        (db),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .f_inx     (f_inx),
    .f_ovf     (f_ovf),
    .f_unf     (f_unf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic d, input rm_t m, input logic s,
                              input logic signed [12:0] e, input logic [56:0] f,
                              input logic [63:0] r, input logic [2:0] fl);
    vec_t v;
    v.db = d; v.rm = m; v.sign = s; v.exp = e; v.fq = f; v.res = r; v.flg = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    in_valid = valid;
    db       = v.db;
    rm       = v.rm;
    sign     = v.sign;
    exp      = v.exp;
    fq       = v.fq;
  endtask

  // flags are packed {inx, ovf, unf}
  task automatic apply(input int i);
    int lat;
    @(negedge clk);
    drive(vecs[i], 1'b1);
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", i), 64'(lat), 64'd2);
    chk($sformatf("v%0d res", i), res, vecs[i].res);
    chk($sformatf("v%0d flags", i), 64'({f_inx, f_ovf, f_unf}), 64'(vecs[i].flg));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int oidx;
    int last_cyc;
    int seen;

    vecs[0]  = mk(1'b1, RNE, 1'b0, 13'sd0,     57'h0080_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b000);
    vecs[1]  = mk(1'b1, RNE, 1'b0, 13'sd0,     57'h0100_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b000);
    vecs[2]  = mk(1'b1, RNE, 1'b0, 13'sd0,     57'h0080_0000_0000_0004, 64'h3FF0_0000_0000_0000, 3'b100);
    vecs[3]  = mk(1'b1, RNE, 1'b0, 13'sd0,     57'h0080_0000_0000_000C, 64'h3FF0_0000_0000_0002, 3'b100);
    vecs[4]  = mk(1'b1, RNE, 1'b0, 13'sd0,     57'h00FF_FFFF_FFFF_FFFC, 64'h4000_0000_0000_0000, 3'b100);
    vecs[5]  = mk(1'b1, RNE, 1'b0, 13'sd1023,  57'h0100_0000_0000_0000, 64'h7FF0_0000_0000_0000, 3'b110);
    vecs[6]  = mk(1'b1, RZ,  1'b0, 13'sd1023,  57'h0100_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF, 3'b110);
    vecs[7]  = mk(1'b1, RU,  1'b1, 13'sd1023,  57'h0100_0000_0000_0000, 64'hFFEF_FFFF_FFFF_FFFF, 3'b110);
    vecs[8]  = mk(1'b1, RD,  1'b1, 13'sd1023,  57'h0100_0000_0000_0000, 64'hFFF0_0000_0000_0000, 3'b110);
    vecs[9]  = mk(1'b1, RNE, 1'b0, 13'sd1023,  57'h00FF_FFFF_FFFF_FFFC, 64'h7FF0_0000_0000_0000, 3'b110);
    vecs[10] = mk(1'b1, RNE, 1'b0, 13'sd1023,  57'h0080_0000_0000_0000, 64'h7FE0_0000_0000_0000, 3'b000);
    vecs[11] = mk(1'b1, RNE, 1'b0, -13'sd1022, 57'h0080_0000_0000_0000, 64'h0010_0000_0000_0000, 3'b000);
    vecs[12] = mk(1'b1, RNE, 1'b1, -13'sd1023, 57'h0080_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b101);
    vecs[13] = mk(1'b0, RNE, 1'b0, -13'sd127,  57'h0080_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b101);
    vecs[14] = mk(1'b0, RNE, 1'b0, 13'sd0,     57'h0080_0000_0000_0000, 64'h0000_0000_3F80_0000, 3'b000);
    vecs[15] = mk(1'b0, RU,  1'b0, 13'sd0,     57'h0080_0000_0000_0001, 64'h0000_0000_3F80_0001, 3'b100);
    vecs[16] = mk(1'b0, RD,  1'b1, 13'sd0,     57'h0080_0000_0000_0001, 64'h0000_0000_BF80_0001, 3'b100);
    vecs[17] = mk(1'b0, RD,  1'b0, 13'sd0,     57'h0080_0000_0000_0001, 64'h0000_0000_3F80_0000, 3'b100);
    vecs[18] = mk(1'b0, RU,  1'b1, 13'sd0,     57'h0080_0000_8000_0000, 64'h0000_0000_BF80_0000, 3'b100);
    vecs[19] = mk(1'b0, RNE, 1'b0, -13'sd126,  57'h0080_0000_0000_0000, 64'h0000_0000_0080_0000, 3'b000);
    vecs[20] = mk(1'b0, RD,  1'b0, 13'sd128,   57'h0080_0000_0000_0000, 64'h0000_0000_7F7F_FFFF, 3'b110);
    vecs[21] = mk(1'b0, RNE, 1'b0, 13'sd127,   57'h00FF_FFFF_8000_0000, 64'h0000_0000_7F80_0000, 3'b110);
    vecs[22] = mk(1'b0, RNE, 1'b0, 13'sd0,     57'h0100_0001_0000_0000, 64'h0000_0000_4000_0000, 3'b100);
    vecs[23] = mk(1'b1, RZ,  1'b0, 13'sd0,     57'h00FF_FFFF_FFFF_FFFC, 64'h3FFF_FFFF_FFFF_FFFF, 3'b100);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset res", res, 64'd0);
    chk("reset flags", 64'({f_inx, f_ovf, f_unf}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      apply(i);
    end

    // backpressure: four back-to-back offers, output stalled for five cycles
    @(negedge clk);
    idx = 0;
    oidx = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 20 && oidx < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (cyc >= 5);
      if (idx < 4) drive(vecs[idx], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (cyc == 4) begin
        chk("bp accepts while stalled", 64'(idx), 64'd2);
        chk("bp in_ready low", 64'(in_ready), 64'd0);
        chk("bp out_valid held", 64'(out_valid), 64'd1);
      end
      if (out_valid && !out_ready) chk($sformatf("bp stall res c%0d", cyc), res, vecs[0].res);
      if (out_valid && out_ready) begin
        chk($sformatf("bp order res %0d", oidx), res, vecs[oidx].res);
        if (oidx > 0) chk($sformatf("bp gap %0d", oidx), 64'(cyc - last_cyc), 64'd1);
        last_cyc = cyc;
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("bp delivered", 64'(oidx), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;

    // reset with two operations in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[1], 1'b1);
    @(negedge clk);
    drive(vecs[5], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("flight out_valid before rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("flight out_valid after rst", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flight ops dropped", 64'(seen), 64'd0);
    apply(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
